// File: rtl/seq_divider_if.sv
// seq_divider_if -- request/result bundle for the sequential divider.
//
// Handshake: the master raises start for one cycle with dividend/divisor
// valid. The request is taken on that rising edge only if busy is low (the
// divider is idle or in its one-cycle result slot); a start seen while busy
// is high is dropped, so busy acts as an inverted ready. Results are valid
// in the single cycle that done is high and then hold until the next
// result or reset.
//
// Signals:
//   start       master -> slave  request pulse
//   dividend    master -> slave  DIVIDEND_W-bit unsigned dividend
//   divisor     master -> slave  DIVISOR_W-bit unsigned divisor
//   busy        slave -> master  division in progress
//   done        slave -> master  one-cycle result strobe
//   quotient    slave -> master  DIVIDEND_W-bit quotient
//   remainder   slave -> master  DIVISOR_W-bit remainder
//   div_by_zero slave -> master  result came from a zero divisor
interface seq_divider_if #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
);
  logic                  start;
  logic [DIVIDEND_W-1:0] dividend;
  logic [DIVISOR_W-1:0]  divisor;
  logic                  busy;
  logic                  done;
  logic [DIVIDEND_W-1:0] quotient;
  logic [DIVISOR_W-1:0]  remainder;
  logic                  div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface

// File: rtl/seq_divider.sv
// seq_divider -- iterative restoring unsigned divider, one quotient bit per
// clock. A divide takes DIVIDEND_W cycles in CALC plus one FIN cycle in
// which done pulses; a zero divisor skips straight to FIN.
//
// Ports:
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus        seq_divider_if slave (start/operands in, busy/done/results out)
//   state_dbg  current FSM state (0 IDLE, 1 CALC, 2 FIN) for observation
module seq_divider #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  seq_divider_if.slave        bus,
  output logic [1:0]          state_dbg
);

  localparam int CW = $clog2(DIVIDEND_W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIN  = 2'd2
  } state_t;

  state_t                state;
  logic [DIVISOR_W-1:0]  d;      // captured divisor
  logic [DIVISOR_W-1:0]  p;      // partial remainder, always < d
  logic [DIVIDEND_W-1:0] q;      // dividend shifting out, quotient shifting in
  logic [CW-1:0]         count;

  // One restoring step. T carries one extra bit so the compare against the
  // divisor sees the full value (up to 2*d-1). The subtraction itself can be
  // done in DIVISOR_W bits because its result is always below d.
  logic [DIVISOR_W:0]    t;
  logic                  ge;
  logic [DIVISOR_W-1:0]  p_next;
  logic [DIVIDEND_W-1:0] q_next;

  always_comb begin
    t      = {p, q[DIVIDEND_W-1]};
    ge     = (t >= {1'b0, d});
    p_next = ge ? (t[DIVISOR_W-1:0] - d) : t[DIVISOR_W-1:0];
    q_next = {q[DIVIDEND_W-2:0], ge};
  end

  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      d               <= '0;
      p               <= '0;
      q               <= '0;
      count           <= '0;
      bus.busy        <= 1'b0;
      bus.done        <= 1'b0;
      bus.quotient    <= '0;
      bus.remainder   <= '0;
      bus.div_by_zero <= 1'b0;
    end else begin
      bus.done <= 1'b0;
      case (state)
        // FIN accepts a new start exactly like IDLE so results can stream.
        IDLE, FIN: begin
          state <= IDLE;
          if (bus.start) begin
            if (bus.divisor != '0) begin
              d        <= bus.divisor;
              p        <= '0;
              q        <= bus.dividend;
              count    <= CW'(DIVIDEND_W);
              bus.busy <= 1'b1;
              state    <= CALC;
            end else begin
              bus.done        <= 1'b1;
              bus.quotient    <= '1;
              bus.remainder   <= '0;
              bus.div_by_zero <= 1'b1;
              state           <= FIN;
            end
          end
        end
        CALC: begin
          p     <= p_next;
          q     <= q_next;
          count <= count - CW'(1);
          // Last iteration: publish the freshly computed step directly so
          // the results appear together with done on entry to FIN.
          if (count == CW'(1)) begin
            bus.busy        <= 1'b0;
            bus.done        <= 1'b1;
            bus.quotient    <= q_next;
            bus.remainder   <= p_next;
            bus.div_by_zero <= 1'b0;
            state           <= FIN;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_divider.sv
module tb_seq_divider;

  localparam int DW  = 8;
  localparam int VW  = 4;
  localparam int RW  = 1 + DW + VW;   // {div_by_zero, quotient, remainder}
  localparam int LAT = DW + 1;

  logic clk;
  logic rst_n;
  logic [1:0] state_dbg;

  seq_divider_if #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) bus();

  seq_divider #(.DIVIDEND_W(DW), .DIVISOR_W(VW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- scoreboard ----------------
  logic [RW-1:0] exp_q[$];
  int unsigned   exp_cyc_q[$];
  logic [RW-1:0] hold_val = '0;
  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
    end
  endtask

  task automatic flag(input string name);
    n_cmp++;
    n_bad++;
    $display("FAIL %s: condition not met (t=%0t)", name, $time);
  endtask

  // Reference: plain arithmetic on the operands.
  function automatic logic [RW-1:0] model(input logic [DW-1:0] a, input logic [VW-1:0] b);
    logic [DW-1:0] qq;
    logic [DW-1:0] rr;
    if (b == 0) return {1'b1, {DW{1'b1}}, {VW{1'b0}}};
    qq = a / b;
    rr = a % b;
    return {1'b0, qq, rr[VW-1:0]};
  endfunction

  // Monitor: pop on every done, otherwise outputs must hold the last result.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          flag("unexpected_done");
        end else begin
          logic [RW-1:0] e;
          int unsigned   ec;
          e  = exp_q.pop_front();
          ec = exp_cyc_q.pop_front();
          check("result", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(e));
          check("done_cycle", cyc, ec);
          hold_val = e;
        end
      end else begin
        check("hold", 32'({bus.div_by_zero, bus.quotient, bus.remainder}), 32'(hold_val));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic pulse(input logic [DW-1:0] a, input logic [VW-1:0] b, input bit push);
    bus.start    = 1'b1;
    bus.dividend = a;
    bus.divisor  = b;
    if (push) begin
      exp_q.push_back(model(a, b));
      exp_cyc_q.push_back(cyc + ((b == 0) ? 1 : LAT));
    end
    @(negedge clk);
    bus.start    = 1'b0;
    bus.dividend = DW'($urandom);
    bus.divisor  = VW'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (bus.busy && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (bus.busy) flag("wait_idle_timeout");
  endtask

  task automatic wait_done();
    int n = 0;
    while (!bus.done && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!bus.done) flag("wait_done_timeout");
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int busy_cnt;
    bus.start    = 1'b0;
    bus.dividend = '0;
    bus.divisor  = '0;
    rst_n        = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_outputs",
          32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic 200/13 with busy duration
    pulse(8'd200, 4'd13, 1'b1);
    busy_cnt = 0;
    while (bus.busy && busy_cnt < 20) begin
      busy_cnt++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(busy_cnt), 32'd8);
    wait_idle();
    @(negedge clk);

    // Boundaries
    pulse(8'd255, 4'd1, 1'b1);  wait_idle(); @(negedge clk);
    pulse(8'd7, 4'd15, 1'b1);   wait_idle(); @(negedge clk);
    pulse(8'd0, 4'd5, 1'b1);    wait_idle(); @(negedge clk);
    pulse(8'd255, 4'd15, 1'b1); wait_idle(); @(negedge clk);

    // Divide by zero, then a normal divide taken in the FIN cycle
    pulse(8'd100, 4'd0, 1'b1);
    wait_idle();
    pulse(8'd100, 4'd3, 1'b1);
    wait_idle(); @(negedge clk);

    // Start while busy is ignored
    pulse(8'd200, 4'd13, 1'b1);
    repeat (2) @(negedge clk);
    pulse(8'd50, 4'd5, 1'b0);
    wait_idle(); repeat (2) @(negedge clk);

    // Back-to-back: second start held during the FIN cycle
    pulse(8'd200, 4'd13, 1'b1);
    wait_done();
    pulse(8'd99, 4'd10, 1'b1);
    wait_idle(); repeat (2) @(negedge clk);

    // Asynchronous reset mid-CALC, off the clock edges
    pulse(8'd200, 4'd13, 1'b1);
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs",
          32'({bus.busy, bus.done, bus.div_by_zero, bus.quotient, bus.remainder}), 32'd0);
    exp_q.delete();
    exp_cyc_q.delete();
    hold_val = '0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    pulse(8'd60, 4'd7, 1'b1);
    wait_idle(); @(negedge clk);

    // Sweep all operand pairs in random order with random gaps
    begin
      int order[$];
      for (int i = 0; i < 4096; i++) order.push_back(i);
      order.shuffle();
      foreach (order[k]) begin
        wait_idle();
        if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 2)) @(negedge clk);
        pulse(DW'(order[k] >> VW), VW'(order[k]), 1'b1);
      end
    end
    wait_idle();

    // Drain
    begin
      int n = 0;
      while (exp_q.size() > 0 && n < 50) begin
        @(negedge clk);
        n++;
      end
      if (exp_q.size() > 0) flag("drain_timeout");
    end
    repeat (3) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
